// File: rtl/lift_pkg.sv
// lift_pkg: shared types and constants for the four-floor lift controller.
package lift_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    UP        = 2'b01,
    DOWN      = 2'b10,
    DOOR_OPEN = 2'b11
  } lift_state_e;

endpackage

// File: rtl/lift_ctrl_if.sv
// lift_ctrl_if: request/state bundle between the floor-request encoder
// (master) and the lift controller (slave).
interface lift_ctrl_if;
  import lift_pkg::*;

  floor_t      floor;
  logic [1:0]  lift_state;

  modport master (output floor, input lift_state);
  modport slave  (input floor, output lift_state);
endinterface

// File: rtl/lift_timer.sv
// lift_timer: load/expire down-counter. Loading N-1 makes done_o assert
// N cycles later; the counter parks at zero once expired.
module lift_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/lift_ctrl.sv
// lift_ctrl: single-car four-floor lift FSM. Samples the requested floor
// only while IDLE, steps one floor per FLOOR_CYCLES toward the latched
// target, then holds DOOR_OPEN for DOOR_CYCLES before returning to IDLE.
// Optional macro LIFT_POS_OUT_EN exposes the current floor on cur_floor_o.
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned FLOOR_CYCLES = 1,
  parameter int unsigned DOOR_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef LIFT_POS_OUT_EN
  output floor_t     cur_floor_o,
`endif
  lift_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_UP   = UP;
  localparam logic [1:0] ST_DOWN = DOWN;
  localparam logic [1:0] ST_DOOR = DOOR_OPEN;

  // Timer reload values are N-1 so expiry lands exactly N cycles later.
  localparam logic [7:0] FLOOR_LD = 8'(FLOOR_CYCLES - 1);
  localparam logic [7:0] DOOR_LD  = 8'(DOOR_CYCLES - 1);

  logic [1:0] state_q, state_d;
  floor_t     cur_floor_q, cur_floor_d;
  floor_t     target_q, target_d;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  lift_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state logic: request sampling, floor stepping and door timing.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    target_d    = target_q;
    tmr_load    = 1'b0;
    tmr_val     = FLOOR_LD;
    case (state_q)
      ST_IDLE: begin
        if (bus.floor > cur_floor_q) begin
          target_d = bus.floor;
          state_d  = ST_UP;
          tmr_load = 1'b1;
        end else if (bus.floor < cur_floor_q) begin
          target_d = bus.floor;
          state_d  = ST_DOWN;
          tmr_load = 1'b1;
        end
      end
      ST_UP: begin
        if (tmr_done) begin
          cur_floor_d = cur_floor_q + 2'd1;
          tmr_load    = 1'b1;
          if (cur_floor_d == target_q) begin
            state_d = ST_DOOR;
            tmr_val = DOOR_LD;
          end
        end
      end
      ST_DOWN: begin
        if (tmr_done) begin
          cur_floor_d = cur_floor_q - 2'd1;
          tmr_load    = 1'b1;
          if (cur_floor_d == target_q) begin
            state_d = ST_DOOR;
            tmr_val = DOOR_LD;
          end
        end
      end
      default: begin
        if (tmr_done) state_d = ST_IDLE;
      end
    endcase
  end

  // State, position and target registers; reset forgets the car position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_floor_q <= 2'd0;
      target_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      target_q    <= target_d;
    end
  end

  assign bus.lift_state = state_q;
`ifdef LIFT_POS_OUT_EN
  assign cur_floor_o = cur_floor_q;
`endif

endmodule

// File: tb/tb_lift_ctrl.sv
// tb_lift_ctrl: table vectors, hand sequences and randomized requests
// checked against a schedule-based reference model of the lift.
module tb_lift_ctrl;
  import lift_pkg::*;

  localparam int FC = 1;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lift_ctrl_if bus();
`ifdef LIFT_POS_OUT_EN
  floor_t cur_floor_o;
`endif

  lift_ctrl #(.FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef LIFT_POS_OUT_EN
    .cur_floor_o (cur_floor_o),
`endif
    .bus         (bus)
  );

  typedef struct {
    logic [1:0] floor;
    logic [1:0] exp_state;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: on accepting a request while idle, the whole journey
  // is scheduled as a queue of expected outputs (travel then door).
  int         m_cur;
  logic [1:0] m_prev;
  logic [1:0] m_q[$];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur  = 0;
    m_prev = 2'b00;
  endtask

  task automatic model_edge();
    int d;
    int req;
    if (!rst_n) begin
      model_reset();
    end else begin
      req = int'(bus.floor);
      if (m_prev == 2'b00 && m_q.size() == 0 && req != m_cur) begin
        d = req - m_cur;
        for (int i = 0; i < (d < 0 ? -d : d) * FC; i++)
          m_q.push_back(d > 0 ? 2'b01 : 2'b10);
        for (int i = 0; i < DC; i++)
          m_q.push_back(2'b11);
        m_cur = req;
      end
      m_prev = (m_q.size() > 0) ? m_q.pop_front() : 2'b00;
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, bus.lift_state, m_prev);
`ifdef LIFT_POS_OUT_EN
    if (m_prev == 2'b00) check({name, "_pos"}, cur_floor_o, 2'(m_cur));
`endif
  endtask

  vec_t       tbl[11];
  logic [1:0] mc_exp[10];

  initial begin
    tbl[0]  = '{2'd3, 2'b01};
    tbl[1]  = '{2'd3, 2'b01};
    tbl[2]  = '{2'd3, 2'b01};
    tbl[3]  = '{2'd3, 2'b11};
    tbl[4]  = '{2'd3, 2'b11};
    tbl[5]  = '{2'd3, 2'b00};
    tbl[6]  = '{2'd1, 2'b10};
    tbl[7]  = '{2'd1, 2'b10};
    tbl[8]  = '{2'd1, 2'b11};
    tbl[9]  = '{2'd1, 2'b11};
    tbl[10] = '{2'd1, 2'b00};
    mc_exp = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};

    model_reset();
    bus.floor = 2'd2;
    rst_n = 1'b0;

    // Reset held with a pending request: must stay idle.
    repeat (4) begin
      tick("reset_hold");
      check("reset_state", bus.lift_state, 2'b00);
    end
    rst_n = 1'b1;
    bus.floor = 2'd0;
    repeat (3) tick("release_idle");

    // Up 0->3 then down 3->1 from the table.
    for (int i = 0; i < 11; i++) begin
      bus.floor = tbl[i].floor;
      tick("model");
      check($sformatf("table[%0d]", i), bus.lift_state, tbl[i].exp_state);
    end

    // Request changed one cycle after UP starts: target stays frozen.
    bus.floor = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick("model");
      check($sformatf("midchange[%0d]", i), bus.lift_state, mc_exp[i]);
      if (i == 0) bus.floor = 2'd1;
    end

    // Go to floor 2, then hold the same request: no door cycle.
    bus.floor = 2'd2;
    repeat (4) tick("to_floor2");
    repeat (10) begin
      tick("model");
      check("same_floor", bus.lift_state, 2'b00);
    end

    // Asynchronous reset between edges while moving down.
    bus.floor = 2'd0;
    tick("model");
    check("down_start", bus.lift_state, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", bus.lift_state, 2'b00);
    model_reset();
    tick("rst_low");
    rst_n = 1'b1;
    bus.floor = 2'd1;
    tick("model");
    check("post_rst_up", bus.lift_state, 2'b01);
    repeat (3) tick("post_rst");

    // Randomized requests against the reference model.
    repeat (400) begin
      if ($urandom_range(3) == 0) bus.floor = 2'($urandom_range(NUM_FLOORS - 1));
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
